muldiv_unit: RTL

- Iterative multiply/divide unit holding the HI/LO registers.
- Sits beside the ALU and feeds the register file write-data mux (MFHI/MFLO select `hi`/`lo` as `wd`).
- Executes MULT, MULTU, DIV and DIVU over DATA_W+1 cycles. MTHI and MTLO write in a single cycle.
- The control path stalls the fetch stage while `busy` is high.

---
 rtl/muldiv_unit_pkg.sv | 33 +++
 rtl/muldiv_unit_divider_core.sv | 56 +++++
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package muldiv_unit_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned MULDIV_CYCLES = WORD_W + 1;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // Per-operation flags captured at the start edge and consumed at commit.
    typedef struct packed {
        logic is_mul;
        logic neg_res;
        logic neg_rem;
        logic div_zero;
        logic div_ovf;
    } md_flags_t;

endpackage

// File: rtl/muldiv_unit_divider_core.sv
// Restoring unsigned divider: one quotient bit per step, MSB of the dividend first.
module muldiv_unit_divider_core
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W:0]   shifted_c;
    logic [DATA_W:0]   diff_c;

    // Partial remainder stays below the divisor, so DATA_W+1 bits hold the trial.
    always_comb begin
        shifted_c = {rem_q, dvd_q[DATA_W-1]};
        diff_c    = shifted_c - {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= '0;
            dvd_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            dvd_q <= dvd_q << 1;
            if (diff_c[DATA_W]) begin
                rem_q <= shifted_c[DATA_W-1:0];
                quo_q <= {quo_q[DATA_W-2:0], 1'b0};
            end else begin
                rem_q <= diff_c[DATA_W-1:0];
                quo_q <= {quo_q[DATA_W-2:0], 1'b1};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO complete in one cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  muldiv_op_t        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned        CNT_W   = $clog2(DATA_W);
    localparam int unsigned        PROD_W  = 2 * DATA_W;
    localparam logic [DATA_W-1:0]  MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    md_state_t         state;
    md_state_t         state_next;
    logic [CNT_W-1:0]  cnt;
    md_flags_t         flags;
    logic [DATA_W-1:0] a_raw;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [PROD_W-1:0] acc;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;

    logic              ld_c;
    logic              step_c;
    logic              commit_c;
    logic              wr_hi_c;
    logic              wr_lo_c;
    logic              last_c;
    logic              op_mul_c;
    logic              op_signed_c;
    logic [DATA_W-1:0] abs_a_c;
    logic [DATA_W-1:0] abs_b_c;
    logic [DATA_W:0]   mul_sum_c;
    logic [PROD_W-1:0] prod_c;
    logic [DATA_W-1:0] res_hi_c;
    logic [DATA_W-1:0] res_lo_c;

    // Operand decode: signed ops iterate on magnitudes, signs are fixed up at commit.
    always_comb begin
        op_mul_c    = (op == MD_MULT) || (op == MD_MULTU);
        op_signed_c = (op == MD_MULT) || (op == MD_DIV);
        abs_a_c     = (op_signed_c && a[DATA_W-1]) ? -a : a;
        abs_b_c     = (op_signed_c && b[DATA_W-1]) ? -b : b;
        last_c      = (cnt == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ld_c       = 1'b0;
        step_c     = 1'b0;
        commit_c   = 1'b0;
        wr_hi_c    = 1'b0;
        wr_lo_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            ld_c       = 1'b1;
                            state_next = ST_RUN;
                        end
                        MD_MTHI: wr_hi_c = 1'b1;
                        MD_MTLO: wr_lo_c = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                commit_c   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Shift-add: add multiplicand into the upper half, then shift the whole product right.
    always_comb begin
        mul_sum_c = {1'b0, acc[PROD_W-1:DATA_W]} + {1'b0, (mplier[0] ? mcand : '0)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            flags  <= '0;
            a_raw  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (ld_c) begin
            cnt            <= '0;
            acc            <= '0;
            a_raw          <= a;
            mcand          <= abs_a_c;
            mplier         <= abs_b_c;
            flags.is_mul   <= op_mul_c;
            flags.neg_res  <= op_signed_c && (a[DATA_W-1] ^ b[DATA_W-1]);
            flags.neg_rem  <= op_signed_c && a[DATA_W-1];
            flags.div_zero <= (b == '0);
            flags.div_ovf  <= op_signed_c && (a == MIN_NEG) && (b == '1);
        end else if (step_c) begin
            cnt <= cnt + CNT_W'(1);
            if (flags.is_mul) begin
                acc    <= {mul_sum_c, acc[DATA_W-1:1]};
                mplier <= mplier >> 1;
            end
        end
    end

    muldiv_unit_divider_core #(
        .DATA_W (DATA_W)
    ) u_divider_core (
        .clk       (clk),
        .reset     (reset),
        .load      (ld_c),
        .step      (step_c && !flags.is_mul),
        .dividend  (abs_a_c),
        .divisor   (abs_b_c),
        .quotient  (quo),
        .remainder (rem)
    );

    // Sign fix-up and special cases applied in the FIX cycle.
    always_comb begin
        prod_c   = flags.neg_res ? -acc : acc;
        res_hi_c = prod_c[PROD_W-1:DATA_W];
        res_lo_c = prod_c[DATA_W-1:0];
        if (!flags.is_mul) begin
            if (flags.div_zero) begin
                res_hi_c = a_raw;
                res_lo_c = '1;
            end else if (flags.div_ovf) begin
                res_hi_c = '0;
                res_lo_c = MIN_NEG;
            end else begin
                res_hi_c = flags.neg_rem ? -rem : rem;
                res_lo_c = flags.neg_res ? -quo : quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != ST_IDLE);
            done <= commit_c;
            if (commit_c) begin
                hi <= res_hi_c;
                lo <= res_lo_c;
            end else begin
                if (wr_hi_c) begin
                    hi <= a;
                end
                if (wr_lo_c) begin
                    lo <= a;
                end
            end
        end
    end

endmodule
